layer_compositor: RTL and testbench
===================================

# layer_compositor

Parametrised pixel compositor feeding the VGA output path. It selects the game-start screen, the failure screen, or a priority-ordered stack of NUM_LAYERS sprite layers over the background, with a configurable transparent colour key. Screen-class changes are smoothed by a per-frame fade-out/fade-in brightness sequencer. Output is a 2-stage registered pipeline with a valid flag.

## Interface
- NUM_LAYERS, 3, number of sprite layers; layer 0 has highest priority.
- COLOR_W, 12, pixel width in bits; three equal channels of CH_W = COLOR_W/3 bits, R in the MSBs; must be divisible by 3.
- KEY_COLOR, 12'h000, transparent colour key for sprite layers.
- FADE_LOG2, 3, fade length is FADE_STEPS = 2**FADE_LOG2 frames per half-fade.

- clk  in  1  pixel clock; only clock.
- rst  in  1  synchronous, active-high reset.
- state  in  4  game state: 0 GAMESTART, 1–4 EASY/NORMAL/HARD/INFERNO, 5 FAILURE, 6–15 treated as play.
- frame_start  in  1  one-cycle pulse per frame, asserted during blanking.
- pix_valid_in  in  1  the current inputs are an active-area pixel.
- background  in  COLOR_W  background pixel.
- layers  in  NUM_LAYERS*COLOR_W  sprite pixels; layer i at bits [i*COLOR_W +: COLOR_W].
- layer_en  in  NUM_LAYERS  per-layer enable.
- gamestart  in  COLOR_W  start-screen pixel.
- failure  in  COLOR_W  failure-screen pixel.
- pixel  out  COLOR_W  composited, faded pixel (registered).
- pix_valid_out  out  1  pix_valid_in delayed 2 cycles.
- fading  out  1  high whenever the fade FSM is not IDLE.

## Operation
- Screen class: START (state 0), FAIL (state 5), PLAY (all others). The displayed class `shown` is a register. It is distinct from the input class.
- Stage 1 (select), registered:
  - START shows gamestart.
  - FAIL shows failure.
  - PLAY shows the lowest index i where layer_en[i]=1 and layers[i] != KEY_COLOR. If no layer qualifies, it shows background.
  - If pix_valid_in=0, stage 1 captures 0.
- Stage 2 (scale), registered: each channel becomes out_c = (c * b) >> FADE_LOG2. Brightness b is in 0..FADE_STEPS. The product is CH_W+FADE_LOG2+1 bits wide. b=FADE_STEPS passes the channel through exactly; b=0 gives black.
- Fade FSM states: IDLE, FADE_OUT, FADE_IN.
  - IDLE: b=FADE_STEPS. If the input class differs from `shown`, go to FADE_OUT. Nothing else changes in that cycle, even if frame_start is also high.
  - FADE_OUT: on frame_start, b decrements.
    - When b reaches 0, `shown` takes the current input class in the same cycle, and the FSM goes to FADE_IN.
    - If the input class returns to `shown` before b reaches 0, go to FADE_IN from the current b. This is a reversal; `shown` is unchanged.
  - FADE_IN: on frame_start, b increments. At b=FADE_STEPS, go to IDLE.
    - If the input class differs from `shown`, go to FADE_OUT from the current b.
- Difficulty changes within PLAY (1↔4 etc.) never trigger a fade.
- b is only updated by frame_start. Stage 2 uses the b value current when the pixel reaches stage 2.

## Timing
- Latency is 2 cycles from the inputs to pixel and pix_valid_out. Throughput is 1 pixel per cycle with no stalls.
- A class change needs one cycle to enter FADE_OUT. The first decrement happens on the next frame_start after that.
- A full transition takes exactly 2*FADE_STEPS frame_start pulses after entry to FADE_OUT.
- fading rises the cycle after the class change is detected. It falls the cycle after the frame_start that makes b=FADE_STEPS.
- Reset values:
  - pixel=0, pix_valid_out=0, fading=0.
  - Both pipeline stages cleared.
  - b=FADE_STEPS, FSM=IDLE, shown=START.
- Reset mid-fade aborts immediately to the reset values. The start screen is displayed at full brightness once the pipeline refills.

## Test plan
- Reset/pipeline: hold rst 2 cycles, then drive state=0, gamestart=12'hABC, pix_valid_in=1 → pixel=0 and pix_valid_out=0 during reset; 12'hABC with pix_valid_out=1 exactly 2 cycles after the first valid input; drop pix_valid_in → pixel=0 two cycles later.
- Priority/key with state already PLAY and IDLE: layers L0=12'h000, L1=12'h0F0, L2=12'h00F, background=12'h111, layer_en=3'b111 → 12'h0F0; layer_en[1]=0 → 12'h00F; all layers 0 → 12'h111; with KEY_COLOR=12'hF0F, L0=12'h000 → 12'h000 (opaque black).
- Fade START→PLAY (FADE_LOG2=3, gamestart=12'hFFF): the first frame_start after the change gives b=7 and pixel=12'hDDD; the 8th gives 12'h000 with shown=PLAY; the 16th gives the unscaled play pixel and fading=0.
- Reversal: during FADE_OUT at b=5, set state back to 0 → FADE_IN; after 3 frame_starts, b=8, IDLE, shown=START, and failure/play content never appears.
- No fade within PLAY: state 1→4 in IDLE → fading stays 0 and the pixel changes within 2 cycles.
- Reset mid-fade: assert rst at b=3 during FADE_IN toward FAIL → the next cycle shows fading=0, pixel=0; after release, gamestart appears at full brightness.

Source files
------------

// File: rtl/layer_compositor.sv
// layer_compositor: picks start/failure screen or the top opaque sprite
// over the background, then scales it by a per-frame fade brightness.
//
// Ports:
//   clk, rst         pixel clock, synchronous active-high reset
//   state            game state (0 start, 5 failure, else play)
//   frame_start      one-cycle pulse per frame, steps the fade
//   pix_valid_in     current inputs are an active-area pixel
//   background       background pixel
//   layers           NUM_LAYERS sprite pixels, layer i at i*COLOR_W
//   layer_en         per-layer enable, layer 0 wins
//   gamestart        start-screen pixel
//   failure          failure-screen pixel
//   pixel            composited, faded pixel (2-cycle latency)
//   pix_valid_out    pix_valid_in delayed by 2 cycles
//   fading           fade sequencer is busy

module layer_compositor #(
  parameter int NUM_LAYERS = 3,
  parameter int COLOR_W = 12,
  parameter logic [COLOR_W-1:0] KEY_COLOR = 12'h000,
  parameter int FADE_LOG2 = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic [3:0] state,
  input  logic frame_start,
  input  logic pix_valid_in,
  input  logic [COLOR_W-1:0] background,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layers,
  input  logic [NUM_LAYERS-1:0] layer_en,
  input  logic [COLOR_W-1:0] gamestart,
  input  logic [COLOR_W-1:0] failure,
  output logic [COLOR_W-1:0] pixel,
  output logic pix_valid_out,
  output logic fading
);

  localparam int CH_W = COLOR_W / 3;
  localparam int FADE_STEPS = 1 << FADE_LOG2;
  localparam int BW = FADE_LOG2 + 1;
  localparam int PW = CH_W + FADE_LOG2 + 1;

  localparam logic [BW-1:0] B_FULL = BW'(FADE_STEPS);
  localparam logic [BW-1:0] B_LAST = BW'(FADE_STEPS - 1);
  localparam logic [BW-1:0] B_ONE = BW'(1);
  localparam logic [BW-1:0] B_ZERO = '0;

  typedef enum logic [1:0] {
    CLS_START,
    CLS_PLAY,
    CLS_FAIL
  } cls_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FADE_OUT,
    S_FADE_IN
  } fsm_t;

  fsm_t r_fsm;
  fsm_t w_fsm_nxt;
  cls_t r_shown;
  cls_t w_shown_nxt;
  cls_t w_in_cls;

  logic [BW-1:0] r_bright;
  logic [BW-1:0] w_bright_nxt;

  logic [COLOR_W-1:0] w_sprite;
  logic [COLOR_W-1:0] w_sel;
  logic [COLOR_W-1:0] w_scaled;

  logic [COLOR_W-1:0] r_s1;
  logic r_v1;
  logic [COLOR_W-1:0] r_s2;
  logic r_v2;

  // Difficulty levels all map to PLAY so they never start a fade.
  always_comb begin
    w_in_cls = CLS_PLAY;
    if (state == 4'd0) begin
      w_in_cls = CLS_START;
    end else if (state == 4'd5) begin
      w_in_cls = CLS_FAIL;
    end
  end

  // Walk from the lowest priority upward so layer 0 overrides last.
  always_comb begin
    w_sprite = background;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (layer_en[i] &&
          layers[i*COLOR_W +: COLOR_W] != KEY_COLOR) begin
        w_sprite = layers[i*COLOR_W +: COLOR_W];
      end
    end
  end

  // Content follows the displayed class, not the requested one.
  always_comb begin
    w_sel = w_sprite;
    unique case (r_shown)
      CLS_START: w_sel = gamestart;
      CLS_FAIL:  w_sel = failure;
      CLS_PLAY:  w_sel = w_sprite;
      default:   w_sel = w_sprite;
    endcase
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    w_bright_nxt = r_bright;
    w_shown_nxt = r_shown;
    unique case (r_fsm)
      S_IDLE: begin
        if (w_in_cls != r_shown) begin
          w_fsm_nxt = S_FADE_OUT;
        end
      end
      S_FADE_OUT: begin
        if (w_in_cls == r_shown) begin
          w_fsm_nxt = S_FADE_IN;
        end else if (r_bright == B_ZERO) begin
          // Re-entered after a reversal at black: swap now.
          w_shown_nxt = w_in_cls;
          w_fsm_nxt = S_FADE_IN;
        end else if (frame_start) begin
          w_bright_nxt = r_bright - B_ONE;
          if (r_bright == B_ONE) begin
            w_shown_nxt = w_in_cls;
            w_fsm_nxt = S_FADE_IN;
          end
        end
      end
      S_FADE_IN: begin
        if (w_in_cls != r_shown) begin
          w_fsm_nxt = S_FADE_OUT;
        end else if (r_bright == B_FULL) begin
          // Reversed before the first fade-out step.
          w_fsm_nxt = S_IDLE;
        end else if (frame_start) begin
          w_bright_nxt = r_bright + B_ONE;
          if (r_bright == B_LAST) begin
            w_fsm_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_fsm_nxt = S_IDLE;
        w_bright_nxt = B_FULL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm <= S_IDLE;
      r_bright <= B_FULL;
      r_shown <= CLS_START;
    end else begin
      r_fsm <= w_fsm_nxt;
      r_bright <= w_bright_nxt;
      r_shown <= w_shown_nxt;
    end
  end

  // Full brightness multiplies by 2**FADE_LOG2, so the shift
  // returns the channel unchanged.
  for (genvar g = 0; g < 3; g++) begin : g_ch
    assign w_scaled[g*CH_W +: CH_W] = CH_W'(
      (PW'(r_s1[g*CH_W +: CH_W]) * PW'(r_bright))
        >> FADE_LOG2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= '0;
      r_v1 <= 1'b0;
      r_s2 <= '0;
      r_v2 <= 1'b0;
    end else begin
      r_s1 <= pix_valid_in ? w_sel : '0;
      r_v1 <= pix_valid_in;
      r_s2 <= w_scaled;
      r_v2 <= r_v1;
    end
  end

  assign pixel = r_s2;
  assign pix_valid_out = r_v2;
  assign fading = (r_fsm != S_IDLE);

endmodule

// File: tb/tb_layer_compositor.sv
// tb_layer_compositor: directed vectors into two compositors
// (key 000 and key F0F), scoreboard queues checked by a monitor.

module tb_layer_compositor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [3:0] state;
  logic frame_start;
  logic pix_valid_in;
  logic [11:0] background;
  logic [35:0] layers;
  logic [2:0] layer_en;
  logic [11:0] gamestart;
  logic [11:0] failure;

  logic [11:0] pix_a, pix_b;
  logic vo_a, vo_b;
  logic fad_a, fad_b;

  layer_compositor #(
    .NUM_LAYERS(3), .COLOR_W(12),
    .KEY_COLOR(12'h000), .FADE_LOG2(3)
  ) u_a (
    .clk(clk), .rst(rst), .state(state),
    .frame_start(frame_start),
    .pix_valid_in(pix_valid_in),
    .background(background), .layers(layers),
    .layer_en(layer_en), .gamestart(gamestart),
    .failure(failure), .pixel(pix_a),
    .pix_valid_out(vo_a), .fading(fad_a)
  );

  layer_compositor #(
    .NUM_LAYERS(3), .COLOR_W(12),
    .KEY_COLOR(12'hF0F), .FADE_LOG2(3)
  ) u_b (
    .clk(clk), .rst(rst), .state(state),
    .frame_start(frame_start),
    .pix_valid_in(pix_valid_in),
    .background(background), .layers(layers),
    .layer_en(layer_en), .gamestart(gamestart),
    .failure(failure), .pixel(pix_b),
    .pix_valid_out(vo_b), .fading(fad_b)
  );

  typedef struct {
    string tag;
    logic [11:0] pix;
    int due;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (vo_a === 1'b1) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_out", 32'(pix_a), 32'hFFFF_FFFF);
      end else begin
        e = qa.pop_front();
        chk({"a_", e.tag}, 32'(pix_a), 32'(e.pix));
        chk({"a_lat_", e.tag}, 32'(cyc), 32'(e.due));
      end
    end
    if (vo_b === 1'b1) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_out", 32'(pix_b), 32'hFFFF_FFFF);
      end else begin
        e = qb.pop_front();
        chk({"b_", e.tag}, 32'(pix_b), 32'(e.pix));
        chk({"b_lat_", e.tag}, 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(string tag, logic [11:0] ea,
                     logic [11:0] eb);
    pix_valid_in = 1'b1;
    qa.push_back('{tag, ea, cyc + 2});
    qb.push_back('{tag, eb, cyc + 2});
    tick();
    pix_valid_in = 1'b0;
    tick();
    tick();
  endtask

  task automatic frames(int n);
    for (int i = 0; i < n; i++) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    state = 4'd0;
    frame_start = 1'b0;
    pix_valid_in = 1'b0;
    background = 12'h000;
    layers = '0;
    layer_en = 3'b000;
    gamestart = 12'hABC;
    failure = 12'hF00;

    tick();
    chk("rst_pixel", 32'(pix_a), 32'h0);
    chk("rst_valid", 32'(vo_a), 32'h0);
    chk("rst_fading", 32'(fad_a), 32'h0);
    tick();
    rst = 1'b0;

    pix("start_abc", 12'hABC, 12'hABC);
    chk("drop_pixel", 32'(pix_a), 32'h0);
    chk("drop_valid", 32'(vo_a), 32'h0);

    // Reversal toward FAIL, back to START at b=5.
    gamestart = 12'hFFF;
    state = 4'd5;
    tick();
    chk("rev_fading_on", 32'(fad_a), 32'h1);
    frames(3);
    pix("rev_b5", 12'h999, 12'h999);
    state = 4'd0;
    tick();
    chk("rev_fading_in", 32'(fad_a), 32'h1);
    frames(2);
    pix("rev_b7", 12'hDDD, 12'hDDD);
    chk("rev_fading_b7", 32'(fad_a), 32'h1);
    frames(1);
    chk("rev_fading_off", 32'(fad_a), 32'h0);
    pix("rev_full", 12'hFFF, 12'hFFF);

    // Full fade START -> PLAY.
    background = 12'h123;
    layer_en = 3'b000;
    state = 4'd1;
    tick();
    frames(1);
    pix("fade_b7", 12'hDDD, 12'hDDD);
    frames(6);
    pix("fade_b1", 12'h111, 12'h111);
    frames(1);
    pix("fade_b0", 12'h000, 12'h000);
    chk("fade_mid_fading", 32'(fad_a), 32'h1);
    frames(7);
    pix("fade_in_b7", 12'h012, 12'h012);
    chk("fade_b15_fading", 32'(fad_a), 32'h1);
    frames(1);
    chk("fade_done_fading", 32'(fad_a), 32'h0);
    pix("fade_done", 12'h123, 12'h123);

    // Priority and colour key, PLAY idle.
    background = 12'h111;
    layers = {12'h00F, 12'h0F0, 12'h000};
    layer_en = 3'b111;
    pix("prio_all", 12'h0F0, 12'h000);
    layer_en = 3'b101;
    pix("prio_l1_off", 12'h00F, 12'h000);
    layers = '0;
    layer_en = 3'b111;
    pix("prio_bg", 12'h111, 12'h000);
    layers = {12'h00F, 12'h0F0, 12'hF0F};
    pix("prio_keyf0f", 12'hF0F, 12'h0F0);
    layers = {12'h00F, 12'h0F0, 12'hABC};
    layer_en = 3'b000;
    pix("prio_none_en", 12'h111, 12'h111);

    // Difficulty change: no fade.
    state = 4'd4;
    tick();
    chk("diff_fading_a", 32'(fad_a), 32'h0);
    chk("diff_fading_b", 32'(fad_b), 32'h0);
    layers = {12'h00F, 12'h0F0, 12'h456};
    layer_en = 3'b001;
    pix("diff_pix", 12'h456, 12'h456);
    chk("diff_fading_end", 32'(fad_a), 32'h0);

    // Reset mid fade-in toward FAIL.
    state = 4'd5;
    tick();
    frames(8);
    frames(3);
    pix("fail_b3", 12'h500, 12'h500);
    chk("fail_b3_fading", 32'(fad_a), 32'h1);
    rst = 1'b1;
    state = 4'd0;
    tick();
    chk("midrst_fading", 32'(fad_a), 32'h0);
    chk("midrst_pixel", 32'(pix_a), 32'h0);
    chk("midrst_valid", 32'(vo_a), 32'h0);
    rst = 1'b0;
    gamestart = 12'hABC;
    pix("post_rst", 12'hABC, 12'hABC);
    chk("post_rst_fading", 32'(fad_a), 32'h0);

    repeat (3) tick();
    chk("sb_drain_a", 32'(qa.size()), 32'h0);
    chk("sb_drain_b", 32'(qb.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
